regfile_scoreboard: RTL

//  Write/read responder for the decode stage: a 64-entry x 32-bit register file
//  (0-31 integer, 32-63 float; index = {flag, 5-bit field}) with two read ports
//  and one writeback port. A per-register pending-write scoreboard tells decode
//  to stall while a source register still has an unretired writer in flight.

---
 rtl/regfile_scoreboard.sv | 104 ++++++++++
 1 files changed

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   Decode-stage register file (NREG x XLEN, index = {float flag, 5-bit field})
//   with two combinational read ports, one writeback port with write-through
//   bypass, and a per-register pending-writer scoreboard that drives stall.
// Ports
//   clk, rstn                      clock, async active-low reset
//   rs0/rs1, rs0_used/rs1_used     decode source addresses and use flags
//   rs0data/rs1data                read data (combinational, bypassed from wb)
//   issue_valid/regwrite/rd        decode instruction leaving decode
//   stall                          decode must hold this cycle
//   wb_en/wb_rd/wb_data            writeback write, retires one writer
//   flush                          squash all in-flight writers
//   sb_err                         sticky protocol error
module regfile_scoreboard #(
  parameter int NREG   = 64,
  parameter int XLEN   = 32,
  parameter int PEND_W = 2,
  localparam int AW    = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [AW-1:0]   rs0,
  input  logic [AW-1:0]   rs1,
  input  logic            rs0_used,
  input  logic            rs1_used,
  output logic [XLEN-1:0] rs0data,
  output logic [XLEN-1:0] rs1data,
  input  logic            issue_valid,
  input  logic            issue_regwrite,
  input  logic [AW-1:0]   issue_rd,
  output logic            stall,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            sb_err
);

  localparam logic [PEND_W-1:0] CMAX = '1;

  logic [XLEN-1:0]             mem [NREG];
  logic [NREG-1:0][PEND_W-1:0] cnt;

  // ---------------- register array ----------------
  // Entry 0 is never written, so it reads as zero without a special case.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (wb_en && wb_rd != '0) begin
      mem[wb_rd] <= wb_data;
    end
  end

  // Write-through bypass so a retiring writer feeds its consumer this cycle.
  logic byp0, byp1;
  assign byp0    = wb_en && wb_rd == rs0 && rs0 != '0;
  assign byp1    = wb_en && wb_rd == rs1 && rs1 != '0;
  assign rs0data = byp0 ? wb_data : mem[rs0];
  assign rs1data = byp1 ? wb_data : mem[rs1];

  // ---------------- pending counters ----------------
  for (genvar r = 0; r < NREG; r++) begin : g_sb
    if (r == 0) begin : g_zero
      assign cnt[r] = '0;
    end else begin : g_reg
      logic [PEND_W-1:0] c;
      logic inc, dec;
      assign inc = issue_valid && issue_regwrite && issue_rd == AW'(r);
      assign dec = wb_en && wb_rd == AW'(r);
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                          c <= '0;
        else if (flush)                     c <= '0;
        // saturate: an illegal issue at max is flagged, not wrapped
        else if (inc && !dec && c != CMAX)  c <= c + 1'b1;
        else if (dec && !inc && c != '0)    c <= c - 1'b1;
      end
      assign cnt[r] = c;
    end
  end

  // ---------------- hazard detection ----------------
  logic [PEND_W-1:0] c0, c1, cd;
  logic hz0, hz1, hzfull;
  assign c0 = cnt[rs0];
  assign c1 = cnt[rs1];
  assign cd = cnt[issue_rd];

  // A source whose only writer is retiring right now is covered by the bypass.
  assign hz0    = rs0_used && rs0 != '0 && c0 != '0 && !(byp0 && c0 == PEND_W'(1));
  assign hz1    = rs1_used && rs1 != '0 && c1 != '0 && !(byp1 && c1 == PEND_W'(1));
  assign hzfull = issue_regwrite && issue_rd != '0 && cd == CMAX &&
                  !(wb_en && wb_rd == issue_rd);
  assign stall  = hz0 | hz1 | hzfull;

  // ---------------- sticky error ----------------
  logic retire_bad;
  assign retire_bad = wb_en && wb_rd != '0 && cnt[wb_rd] == '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                     sb_err <= 1'b0;
    else if (retire_bad || (issue_valid && stall)) sb_err <= 1'b1;
  end

endmodule
